// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//
// Up/down counter with a programmable modulus. It supports parallel load,
// synchronous clear and a count enable. Each end of the range either wraps
// or saturates. It reports terminal count, a one-cycle wrap pulse and a
// sticky overflow flag.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MODULO   : count range is 0..MODULO-1 (2..2^WIDTH)
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset, clears all state
//   clear    : synchronous clear of out, wrap and ovf
//   load     : synchronous parallel load of load_val (clamped to MODULO-1)
//   load_val : value to load
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   out      : registered count value
//   tc       : combinational terminal count for the current direction
//   wrap     : registered one-cycle pulse marking a wrap
//   ovf      : registered sticky overflow/underflow flag
module updown_mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULO   = 256,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // The modulus is held in WIDTH+1 bits so that MODULO = 2^WIDTH still fits.
  localparam logic [WIDTH:0]   L_MOD     = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   L_MAX     = (WIDTH+1)'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0] L_MAX_OUT = WIDTH'(MODULO - 64'd1);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next_out;
  logic             w_next_wrap;
  logic             w_next_ovf;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_ok;

  assign w_at_max  = ({1'b0, r_out} == L_MAX);
  assign w_at_zero = (r_out == '0);
  assign w_load_ok = ({1'b0, load_val} < L_MOD);

  // Next-state selection in priority order: clear, then load, then count.
  // The wrap pulse defaults low, so it lasts only for the edge that wrapped.
  always_comb begin
    w_next_out  = r_out;
    w_next_wrap = 1'b0;
    w_next_ovf  = r_ovf;
    if (clear) begin
      w_next_out = '0;
      w_next_ovf = 1'b0;
    end else if (load) begin
      w_next_out = w_load_ok ? load_val : L_MAX_OUT;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
          w_next_ovf = 1'b1;
          if (!SATURATE) begin
            w_next_out  = '0;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_out = r_out + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_next_ovf = 1'b1;
          if (!SATURATE) begin
            w_next_out  = L_MAX_OUT;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_out = r_out - WIDTH'(1);
        end
      end
    end
  end

  // State register. Reset clears everything without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_out  <= w_next_out;
      r_wrap <= w_next_wrap;
      r_ovf  <= w_next_ovf;
    end
  end

  // Terminal count follows the direction input immediately.
  assign tc   = up ? w_at_max : w_at_zero;
  assign out  = r_out;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Testbench for updown_mod_counter. It runs three instances side by side:
// MODULO=10 wrapping, MODULO=10 saturating and MODULO=256 wrapping. All three
// share one stimulus stream. Each instance is compared against an arithmetic
// reference model.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       load;
  logic [7:0] loadVal;
  logic       en;
  logic       up;

  logic [7:0] out0, out1, out2;
  logic       tc0, tc1, tc2;
  logic       wrap0, wrap1, wrap2;
  logic       ovf0, ovf1, ovf2;

  int vectors    = 0;
  int miscompares = 0;

  int modV [3] = '{10, 10, 256};
  bit satV [3] = '{1'b0, 1'b1, 1'b0};
  int mCnt [3];
  bit mWrap[3];
  bit mOvf [3];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(8), .MODULO(10), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(loadVal),
    .en(en), .up(up), .out(out0), .tc(tc0), .wrap(wrap0), .ovf(ovf0));

  updown_mod_counter #(.WIDTH(8), .MODULO(10), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(loadVal),
    .en(en), .up(up), .out(out1), .tc(tc1), .wrap(wrap1), .ovf(ovf1));

  updown_mod_counter #(.WIDTH(8), .MODULO(256), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(loadVal),
    .en(en), .up(up), .out(out2), .tc(tc2), .wrap(wrap2), .ovf(ovf2));

  // Packs one instance's outputs as {out, tc, wrap, ovf}.
  function automatic logic [10:0] getObs(input int i);
    case (i)
      0:       return {out0, tc0, wrap0, ovf0};
      1:       return {out1, tc1, wrap1, ovf1};
      default: return {out2, tc2, wrap2, ovf2};
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mCnt[i]  = 0;
      mWrap[i] = 1'b0;
      mOvf[i]  = 1'b0;
    end
  endtask

  // The reference steps the count as a signed integer. It then folds the
  // result back into range with modular arithmetic (wrap) or clamping
  // (saturate).
  task automatic modelStep(input bit c, input bit l, input int lv, input bit e, input bit u);
    int  nxt;
    bit  outside;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        mCnt[i]  = 0;
        mWrap[i] = 1'b0;
        mOvf[i]  = 1'b0;
      end else if (l) begin
        mCnt[i]  = (lv < modV[i]) ? lv : modV[i] - 1;
        mWrap[i] = 1'b0;
      end else if (e) begin
        nxt     = mCnt[i] + (u ? 1 : -1);
        outside = (nxt < 0) || (nxt >= modV[i]);
        if (outside) mOvf[i] = 1'b1;
        if (satV[i]) begin
          mCnt[i]  = (nxt < 0) ? 0 : ((nxt > modV[i] - 1) ? modV[i] - 1 : nxt);
          mWrap[i] = 1'b0;
        end else begin
          mCnt[i]  = (nxt + modV[i]) % modV[i];
          mWrap[i] = outside;
        end
      end else begin
        mWrap[i] = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [10:0] o;
    logic        expTc;
    logic [7:0]  expOut;
    for (int i = 0; i < 3; i++) begin
      o      = getObs(i);
      expOut = 8'(mCnt[i]);
      expTc  = up ? (mCnt[i] == modV[i] - 1) : (mCnt[i] == 0);
      vectors++;
      assert (o[10:3] === expOut) else begin
        miscompares++;
        $error("FAIL %s[%0d].out observed=%0d expected=%0d", tag, i, o[10:3], expOut);
      end
      vectors++;
      assert (o[2] === expTc) else begin
        miscompares++;
        $error("FAIL %s[%0d].tc observed=%b expected=%b", tag, i, o[2], expTc);
      end
      vectors++;
      assert (o[1] === mWrap[i]) else begin
        miscompares++;
        $error("FAIL %s[%0d].wrap observed=%b expected=%b", tag, i, o[1], mWrap[i]);
      end
      vectors++;
      assert (o[0] === mOvf[i]) else begin
        miscompares++;
        $error("FAIL %s[%0d].ovf observed=%b expected=%b", tag, i, o[0], mOvf[i]);
      end
    end
  endtask

  // Drives the inputs away from the edge and lets one rising edge pass.
  // It then advances the model and checks just after the edge.
  task automatic applyStimulus(input bit c, input bit l, input int lv,
                               input bit e, input bit u, input string tag);
    clear   = c;
    load    = l;
    loadVal = 8'(lv);
    en      = e;
    up      = u;
    @(posedge clk);
    modelStep(c, l, lv, e, u);
    #1 checkOutput(tag);
  endtask

  initial begin
    int r;
    bit rc, rl, re, ru;
    int rlv;

    reset   = 1'b0;
    clear   = 1'b0;
    load    = 1'b0;
    loadVal = '0;
    en      = 1'b0;
    up      = 1'b1;
    modelReset();

    // Reset and free run
    #2 reset = 1'b1;
    #1 checkOutput("resetAsserted");
    repeat (2) @(posedge clk);
    #1 checkOutput("resetHold");
    @(negedge clk) reset = 1'b0;
    repeat (25) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, "freeRunUp");

    // Down wrap and direction change
    applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b1, "load2");
    repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, "downWrap");
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, "dirChange");
    up = 1'b0;
    #1 checkOutput("tcFollowsDown");
    up = 1'b1;
    #1 checkOutput("tcFollowsUp");

    // Saturate behaviour (all instances see it; the saturating one holds)
    applyStimulus(1'b0, 1'b1, 8, 1'b0, 1'b1, "load8");
    repeat (4)  applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, "satUp");
    repeat (10) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, "satDown");

    // Priority and clamping
    applyStimulus(1'b1, 1'b1, 5,   1'b1, 1'b1, "clearWins");
    applyStimulus(1'b0, 1'b1, 200, 1'b0, 1'b1, "loadClamp");
    applyStimulus(1'b0, 1'b1, 3,   1'b1, 1'b1, "loadBeatsEn");

    // Async reset mid-count
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, "clearBeforeRun");
    repeat (127) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, "countTo7F");
    #2 reset = 1'b1;
    modelReset();
    #1 checkOutput("asyncReset");
    @(posedge clk);
    #1 checkOutput("resetHeldEn");
    @(negedge clk) reset = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, "resumeAfterReset");

    // Full-range rollover
    applyStimulus(1'b0, 1'b1, 255, 1'b0, 1'b1, "loadFF");
    applyStimulus(1'b0, 1'b0, 0,   1'b1, 1'b1, "rollUp");
    applyStimulus(1'b0, 1'b0, 0,   1'b1, 1'b0, "rollDown");
    applyStimulus(1'b0, 1'b0, 0,   1'b0, 1'b0, "wrapDrops");

    // Randomized traffic
    repeat (400) begin
      r   = $urandom_range(0, 99);
      rc  = (r < 3);
      rl  = (r >= 3) && (r < 10);
      rlv = $urandom_range(0, 255);
      re  = ($urandom_range(0, 3) != 0);
      ru  = $urandom_range(0, 1) != 0;
      applyStimulus(rc, rl, rlv, re, ru, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
